// File: rtl/mem_ctrl_pkg.sv
// Shared widths, opcodes, FSM states and the request record for the memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO; the head entry is visible on rdata whenever not empty.
module mem_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Queued single-port memory controller: FIFO of requests, IDLE/ACCESS/RESP sequencer,
// registered memory-side outputs held through the response handshake.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int QDEPTH  = 2,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_operation,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  localparam int         CW        = $clog2(QDEPTH) + 1;
  localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT);

  req_t          in_req, head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_write_q, resp_write_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_op_q, mem_op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  assign in_req    = '{write: req_write, addr: req_addr, data: req_wdata};
  assign req_ready = ~fifo_full;
  assign fifo_push = req_valid & req_ready;
  assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;

  mem_req_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata(in_req),
    .pop  (fifo_pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    mem_op_d     = mem_op_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          wr_d        = head.write;
          mem_addr_d  = head.addr;
          mem_wdata_d = head.data;
          mem_op_d    = (head.write == OP_WRITE);
          cnt_d       = (head.write == OP_WRITE) ? 4'd0 : WAIT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q == OP_WRITE) begin
          // Memory commits on this edge while mem_operation is still high.
          mem_op_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_write_d = OP_WRITE;
          resp_rdata_d = '0;
          state_d      = RESP;
        end else if (cnt_q <= 4'd1) begin
          cnt_d        = 4'd0;
          resp_valid_d = 1'b1;
          resp_write_d = OP_READ;
          resp_rdata_d = mem_dataOut;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_op_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
      mem_op_q     <= mem_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_write    = resp_write_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_operation = mem_op_q;
  assign mem_address   = mem_addr_q;
  assign mem_dataIn    = mem_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: scoreboard of expected responses plus cycle-level checks.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       req_valid, req_ready, req_write, resp_valid, resp_ready, resp_write, mem_operation;
  logic [7:0] req_addr, req_wdata, resp_rdata, mem_address, mem_dataIn, mem_dataOut;
  // Instance B: RD_WAIT = 3
  logic       req_valid_b, req_ready_b, req_write_b, resp_valid_b, resp_ready_b, resp_write_b, mem_operation_b;
  logic [7:0] req_addr_b, req_wdata_b, resp_rdata_b, mem_address_b, mem_dataIn_b, mem_dataOut_b;

  mem_ctrl #(.QDEPTH(2), .RD_WAIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata),
    .mem_operation(mem_operation), .mem_address(mem_address),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  mem_ctrl #(.QDEPTH(2), .RD_WAIT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_write(resp_write_b),
    .resp_rdata(resp_rdata_b),
    .mem_operation(mem_operation_b), .mem_address(mem_address_b),
    .mem_dataIn(mem_dataIn_b), .mem_dataOut(mem_dataOut_b)
  );

  // Memory models (combinational read, posedge write)
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       loaded = 1'b0;
  assign mem_dataOut   = mem_a[mem_address];
  assign mem_dataOut_b = mem_b[mem_address_b];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'h00;
        mem_b[i] <= 8'h00;
      end
      mem_a[8'h02] <= 8'h68;
      mem_b[8'h00] <= 8'h10;
      loaded <= 1'b1;
    end else begin
      if (mem_operation)   mem_a[mem_address]   <= mem_dataIn;
      if (mem_operation_b) mem_b[mem_address_b] <= mem_dataIn_b;
    end
  end

  typedef struct {
    logic       w;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] ref_mem [256];
  int         checks = 0;
  int         errors = 0;
  int         wr_cycles = 0;
  logic [7:0] last_wr_addr = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request on instance A; must be called at a negedge, returns at the negedge after transfer.
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", req_ready, 1);
    if (w) ref_mem[a] = d;
    q.push_back('{w, w ? 8'h00 : ref_mem[a]});
    @(negedge clk);
  endtask

  // Response monitor: handshake occurs at the coming posedge when valid and ready are both high now.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && resp_valid && resp_ready) begin
      if (q.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("resp_write", resp_write, e.w);
        chk("resp_rdata", resp_rdata, e.d);
      end
    end
    if (mem_operation) begin
      wr_cycles++;
      last_wr_addr = mem_address;
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[8'h02] = 8'h68;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
    req_valid_b = 0; req_write_b = 0; req_addr_b = 0; req_wdata_b = 0; resp_ready_b = 1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_write", resp_write, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_op", mem_operation, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_din", mem_dataIn, 0);
    rst_n = 1'b1;
    chk("rst_req_ready", req_ready, 1);

    // Single read of preloaded 0x02
    wr_cycles = 0;
    send(1'b0, 8'h02, 8'h00);
    req_valid = 1'b0;
    chk("rd_lat_t0", resp_valid, 0);
    @(negedge clk);
    chk("rd_lat_t1", resp_valid, 0);
    chk("rd_addr", mem_address, 8'h02);
    @(negedge clk);
    chk("rd_lat_t2", resp_valid, 1);
    chk("rd_data", resp_rdata, 8'h68);
    @(negedge clk);
    chk("rd_lat_t3", resp_valid, 0);
    chk("rd_no_write", wr_cycles, 0);

    // Write then read-back of the same address
    wr_cycles = 0;
    send(1'b1, 8'h05, 8'hA5);
    send(1'b0, 8'h05, 8'h00);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("wr_one_cycle", wr_cycles, 1);
    chk("wr_addr", last_wr_addr, 8'h05);
    chk("wr_mem", mem_a[8'h05], 8'hA5);
    drain();

    // Stalled response with a full FIFO
    resp_ready = 1'b0;
    send(1'b1, 8'h10, 8'h11);
    send(1'b0, 8'h10, 8'h00);
    send(1'b0, 8'h02, 8'h00);
    req_valid = 1'b0;
    chk("stall_full", req_ready, 0);
    chk("stall_valid0", resp_valid, 1);
    repeat (3) @(negedge clk);
    chk("stall_ready", req_ready, 0);
    chk("stall_valid", resp_valid, 1);
    chk("stall_write", resp_write, 1);
    chk("stall_rdata", resp_rdata, 0);
    chk("stall_addr", mem_address, 8'h10);
    chk("stall_din", mem_dataIn, 8'h11);
    chk("stall_mem_op", mem_operation, 0);
    resp_ready = 1'b1;
    send(1'b1, 8'h20, 8'h22);
    req_valid = 1'b0;
    drain();
    chk("stall_wr_mem", mem_a[8'h20], 8'h22);

    // Longer read wait on instance B
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 8'h00;
    chk("b_ready", req_ready_b, 1);
    @(negedge clk);
    req_valid_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("b_wait_valid", resp_valid_b, 0);
      chk("b_wait_addr", mem_address_b, 8'h00);
      chk("b_wait_mem_op", mem_operation_b, 0);
    end
    @(negedge clk);
    chk("b_valid", resp_valid_b, 1);
    chk("b_write", resp_write_b, 0);
    chk("b_rdata", resp_rdata_b, 8'h10);

    // Reset in the middle of a write access
    send(1'b1, 8'h30, 8'h33);
    send(1'b0, 8'h30, 8'h00);
    req_valid = 1'b0;
    chk("mid_wr_active", mem_operation, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_op", mem_operation, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", req_ready, 1);
    repeat (4) @(negedge clk);
    chk("post_rst_valid", resp_valid, 0);
    chk("post_rst_mem_op", mem_operation, 0);
    send(1'b0, 8'h02, 8'h00);
    req_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 2: request queue depth in entries, power of two, >= 2.
REQ-002 SHALL have parameter RD_WAIT, default 1: cycles the read address is held before sampling, range 1..15.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  requester has a request.
REQ-006 req_ready  out  1  controller accepts a request this cycle.
REQ-007 req_write  in  1  request type: 1 = write, 0 = read.
REQ-008 req_addr  in  8  request byte address.
REQ-009 req_wdata  in  8  write data; ignored for reads.
REQ-010 resp_valid  out  1  response available.
REQ-011 resp_ready  in  1  requester takes the response.
REQ-012 resp_write  out  1  echo of the completed request type.
REQ-013 resp_rdata  out  8  read data; 0 for write responses.
REQ-014 mem_operation  out  1  memory write enable; memory writes on posedge when high.
REQ-015 mem_address  out  8  memory address.
REQ-016 mem_dataIn  out  8  memory write data.
REQ-017 mem_dataOut  in  8  memory read data, combinational from mem_address.

Function
REQ-018 A request SHALL transfer on a posedge where req_valid and req_ready are both 1; it is pushed into an in-order FIFO.
REQ-019 req_ready SHALL equal not-full; there is no push-when-full bypass, even if a pop happens in the same cycle.
REQ-020 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-021 IDLE: if the FIFO is non-empty, pop the head into working registers, load the wait counter (RD_WAIT for reads, 0 for writes), and go to ACCESS; otherwise stay in IDLE.
REQ-022 ACCESS, read:
- mem_operation = 0, mem_address = working address.
- Decrement the counter each cycle.
- When the counter reaches 0, capture mem_dataOut into resp_rdata at that posedge and go to RESP.
REQ-023 ACCESS, write:
- mem_operation = 1 for exactly one cycle, with mem_address and mem_dataIn = working registers.
- Go to RESP at that posedge, so memory commits on the same edge.
REQ-024 RESP: resp_valid = 1. resp_write, resp_rdata and the memory outputs SHALL be held stable until resp_ready = 1; then go to IDLE.
REQ-025 mem_operation, mem_address and mem_dataIn SHALL be registered outputs; mem_operation SHALL be 0 in every state except ACCESS-write.
REQ-026 Latency (FIFO empty, request accepted at edge T, RD_WAIT = 1, resp_ready held high):
- ACCESS runs during cycle T+1..T+2.
- resp_valid is 1 from edge T+2 to edge T+3.
- Read latency = 1 + RD_WAIT cycles to resp_valid.
REQ-027 Requests SHALL complete strictly in order; a read queued behind a write to the same address SHALL return the written data.
REQ-028 Throughput: at most one request per 2 + wait cycles. A stalled resp_ready SHALL stall memory access while the FIFO still accepts up to QDEPTH requests.
REQ-029 Simultaneous push and pop in IDLE SHALL keep the FIFO count unchanged and preserve order.
REQ-030 The FIFO count SHALL use log2(QDEPTH)+1 bits; pointers SHALL wrap modulo QDEPTH.

Reset
REQ-031 rst_n low SHALL asynchronously force:
- FSM = IDLE, FIFO empty;
- resp_valid, resp_write, resp_rdata, mem_operation, mem_address, mem_dataIn all = 0.
REQ-032 Reset mid-ACCESS-write SHALL drop mem_operation immediately; the write may be lost, and no response is produced. Queued requests are discarded.
REQ-033 After rst_n rises, req_ready SHALL be 1 on the first cycle.

Structure
REQ-034 Package mem_ctrl_pkg SHALL hold ADDR_W = 8, DATA_W = 8, the state enum (IDLE, ACCESS, RESP), and OP_READ = 0 / OP_WRITE = 1.
REQ-035 The FIFO SHALL be sub-module mem_req_fifo (width 1 + ADDR_W + DATA_W, depth QDEPTH, push/pop/full/empty/count).

Verification
REQ-036 Memory model preloaded 0x02 = 0x68; read 0x02 with resp_ready = 1 -> resp_valid at T+2, resp_rdata = 0x68, resp_write = 0, mem_operation never high.
REQ-037 Write 0x05 <- 0xA5, then read 0x05 back-to-back -> mem_operation high for exactly one cycle with address 0x05; the read returns 0xA5.
REQ-038 resp_ready = 0, push 3 requests (QDEPTH = 2) -> req_ready drops after the FIFO fills; the response is held stable; after release, all complete in order with no loss.
REQ-039 RD_WAIT = 3, read 0x00 preloaded 0x10 -> mem_address stable 3 cycles; resp_valid at T+4 with 0x10.
REQ-040 Assert rst_n low during ACCESS-write -> mem_operation = 0 the same cycle, resp_valid = 0, FIFO empty, req_ready = 1 after release.
